fifo_drain_control: RTL and testbench
=====================================

# fifo_drain_control

Read-side controller for the per-lane input FIFOs that feed the systolic array. It issues skewed, lockstep read enables so that lane i is read one step after lane i-1, which produces the diagonal wavefront the array expects. It stalls the whole wavefront whenever any currently active lane's FIFO is empty. It flags each returned word with a per-lane valid and asserts `completed` once every enabled lane has delivered `read_count` words.

## Interface
- `array_size`, 9: number of FIFO lanes / array rows.
- `dim_data_size`, 16: width of dimension/count inputs.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: when low, state, counters and `rd_en_out` are frozen/deasserted.
- `start`  in  1: single-cycle pulse; accepted only in IDLE or DONE.
- `offset`  in  8: lanes with index < `offset` are never read; skew is measured from lane `offset`.
- `read_count`  in  `dim_data_size`: words to read per enabled lane; sampled at accepted `start`.
- `fifo_empty_in`  in  `array_size`: per-lane FIFO empty flags.
- `rd_en_out`  out  `array_size`: per-lane FIFO read enables.
- `valid_out`  out  `array_size`: `rd_en_out` delayed one cycle; marks FIFO read data as valid.
- `busy`  out  1: high in RUN and FLUSH.
- `completed`  out  1: high in DONE.

## Operation
- States:
  - IDLE -> RUN on accepted `start`.
  - RUN -> FLUSH when the step counter `t` reaches `read_count + (array_size-1-offset)` steps issued.
  - FLUSH -> DONE after one cycle.
  - DONE -> RUN on `start`.
- Degenerate starts: if `read_count==0` or `offset>=array_size`, accepted `start` goes directly to DONE. No `rd_en_out` is ever asserted.
- Sampling: `read_count` and `offset` are latched at `start`. Later changes have no effect until the next `start`.
- Lane activity: for i >= offset, k = i - offset, lane i is active at step `t` when k <= t < k + `read_count`.
- Lockstep step: a step fires in RUN when `enable`=1 and no active lane has `fifo_empty_in`=1.
  - On a step, `rd_en_out[i]`=1 for every active lane and `t` increments.
  - Otherwise `rd_en_out`=0 and `t` holds. Lanes never advance independently.
- Counter width: `t` is `dim_data_size+1` bits and never wraps. Max value is `read_count + array_size - 1`.
- Empty flags of inactive lanes (not yet started, finished, or below `offset`) are ignored.
- `valid_out[i]` is registered `rd_en_out[i]` and updates every cycle regardless of `enable`, so in-flight data is never lost.
- `start` while in RUN or FLUSH is ignored.
- Reset at any time returns the block to IDLE and discards partial progress.

## Timing
- Reset values: state=IDLE, `t`=0, `rd_en_out`=0, `valid_out`=0, `busy`=0, `completed`=0.
- `start` sampled high at edge N:
  - `busy`=1 from cycle N+1.
  - First possible `rd_en_out[offset]` in cycle N+1 (combinational from state/`t`/empty, qualified by `enable`).
- Read data is consumed one cycle after `rd_en_out`, qualified by `valid_out`.
- With no stalls, the last `rd_en_out` occurs in cycle N + `read_count` + (array_size-1-offset).
  - The final `valid_out` follows one cycle later, in FLUSH.
  - `completed` rises the cycle after that, when `busy` falls.
- `completed` holds high in DONE. It clears on the cycle after an accepted restart `start`.
- `rd_en_out` is 0 in IDLE, FLUSH and DONE, and whenever `enable`=0.

## Test plan
- Basic wavefront: array_size=3, offset=0, read_count=4, FIFOs never empty, `start` at cycle 0.
  - Cycle 1: `rd_en_out`=001, then 011, 111, 111, 110, 100.
  - `valid_out` is the same sequence shifted by +1.
  - `completed`=1 at cycle 8; each lane sees exactly 4 reads.
- Stall: same setup, `fifo_empty_in[1]`=1 during cycles 3-4.
  - Cycles 3-4: `rd_en_out`=000 and `t` holds.
  - The pattern resumes at cycle 5 with 111; `completed` is delayed by 2 cycles.
- Inactive-lane empty: lane 2 empty during cycle 1 (before its turn).
  - No stall; cycle 1 `rd_en_out`=001.
- Offset: array_size=3, offset=1, read_count=2.
  - `rd_en_out[0]` always 0; sequence 010, 110, 100.
  - `completed` two cycles after the last read.
- Degenerate starts: read_count=0, then separately offset=5.
  - Each goes to `completed`=1 on the cycle after `start`, with no `rd_en_out` asserted.
- Enable and reset:
  - `enable` low for 3 cycles mid-run: `rd_en_out`=0 and `t` frozen; the run resumes exactly where it stopped.
  - `reset` asserted mid-RUN: all outputs 0 immediately; a fresh `start` reproduces the basic wavefront.

Source files
------------

// File: rtl/fifo_drain_control.sv
// fifo_drain_control: skewed lockstep read enables for the per-lane systolic-array input FIFOs,
// stalling the whole wavefront when any active lane's FIFO is empty.
module fifo_drain_control #(
  parameter int array_size = 9,
  parameter int dim_data_size = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [7:0]               offset,
  input  logic [dim_data_size-1:0] read_count,
  input  logic [array_size-1:0]    fifo_empty_in,
  output logic [array_size-1:0]    rd_en_out,
  output logic [array_size-1:0]    valid_out,
  output logic                     busy,
  output logic                     completed
);
  localparam int tw = dim_data_size + 1;
  localparam int cw = dim_data_size + 2;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state;
  logic [tw-1:0] t, last;
  logic [dim_data_size-1:0] rc_q;
  logic [7:0] off_q;
  logic [array_size-1:0] act;
  logic step, degen;
  assign last = tw'(rc_q) + tw'(array_size - 1) - tw'(off_q);
  assign degen = read_count == '0 || int'(offset) >= array_size;
  assign step = state == RUN && enable && (act & fifo_empty_in) == '0;
  assign rd_en_out = step ? act : '0;
  // lane i (k = i - offset) is active for k <= t < k + read_count; rewritten without subtraction
  always_comb begin
    act = '0;
    for (int i = 0; i < array_size; i++)
      act[i] = 8'(i) >= off_q && cw'(t) + cw'(off_q) >= cw'(i) &&
               cw'(t) + cw'(off_q) < cw'(i) + cw'(rc_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      t <= '0;
      rc_q <= '0;
      off_q <= '0;
      valid_out <= '0;
      busy <= 1'b0;
      completed <= 1'b0;
    end else begin
      valid_out <= rd_en_out;
      if (enable)
        case (state)
          IDLE, DONE: if (start) begin
            rc_q <= read_count;
            off_q <= offset;
            t <= '0;
            state <= degen ? DONE : RUN;
            busy <= !degen;
            completed <= degen;
          end
          RUN: if (step) begin
            t <= t + tw'(1);
            if (t + tw'(1) == last) state <= FLUSH;
          end
          FLUSH: begin
            state <= DONE;
            busy <= 1'b0;
            completed <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_fifo_drain_control.sv
// tb_fifo_drain_control: randomized scoreboard bench; expected per-step lane masks are queued at start
// and popped by a monitor each time the wavefront is expected to advance.
module tb_fifo_drain_control;
  localparam int n = 3;
  localparam int dw = 16;
  logic clk = 1'b0;
  logic reset, enable, start, busy, completed;
  logic [7:0] offset;
  logic [dw-1:0] read_count;
  logic [n-1:0] fifo_empty_in, rd_en_out, valid_out;
  int vectors = 0, errors = 0;
  int phase = 0;
  logic [n-1:0] mq[$];
  logic [n-1:0] prev_rd = '0;
  logic [n-1:0] exp_rd;

  fifo_drain_control #(.array_size(n), .dim_data_size(dw)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .offset(offset),
    .read_count(read_count), .fifo_empty_in(fifo_empty_in), .rd_en_out(rd_en_out),
    .valid_out(valid_out), .busy(busy), .completed(completed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // phase: 0 idle, 1 run, 2 flush, 3 done; queue head is the lane set of the next step
  always @(negedge clk) begin
    if (reset) begin
      check("reset_rd_en", rd_en_out, 0);
      check("reset_valid", valid_out, 0);
      check("reset_busy", busy, 0);
      check("reset_completed", completed, 0);
      phase = 0;
      mq.delete();
      prev_rd = '0;
    end else begin
      exp_rd = (phase == 1 && mq.size() > 0 && enable && (mq[0] & fifo_empty_in) == '0) ? mq[0] : '0;
      check("rd_en_out", rd_en_out, exp_rd);
      check("valid_out", valid_out, prev_rd);
      check("busy", busy, phase == 1 || phase == 2);
      check("completed", completed, phase == 3);
      prev_rd = exp_rd;
      if (enable)
        case (phase)
          0, 3: if (start) phase = mq.size() == 0 ? 3 : 1;
          1: if (exp_rd != '0) begin
            void'(mq.pop_front());
            if (mq.size() == 0) phase = 2;
          end
          2: phase = 3;
          default: ;
        endcase
    end
  end

  // lane i takes rc consecutive steps beginning at step i-off
  task automatic issue_start(input int rc, input int off);
    logic [n-1:0] tmp[64];
    @(posedge clk); #1;
    foreach (tmp[s]) tmp[s] = '0;
    if (rc > 0 && off < n) begin
      for (int i = off; i < n; i++)
        for (int j = 0; j < rc; j++) tmp[i - off + j][i] = 1'b1;
      for (int s = 0; s < rc + n - 1 - off; s++) mq.push_back(tmp[s]);
    end
    start = 1'b1;
    enable = 1'b1;
    read_count = dw'(rc);
    offset = 8'(off);
    @(posedge clk); #1;
    start = 1'b0;
    read_count = dw'($urandom);
    offset = 8'($urandom);
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!completed && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("done_within_bound", completed, 1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    fifo_empty_in = '0;
    offset = '0;
    read_count = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue_start(4, 0);
    wait_done(50, cyc);
    check("basic_latency", cyc, 7);
    issue_start(4, 0);
    fork
      wait_done(50, cyc);
      begin
        repeat (2) @(posedge clk);
        #1 fifo_empty_in = 3'b010;
        repeat (2) @(posedge clk);
        #1 fifo_empty_in = '0;
      end
    join
    check("stall_latency", cyc, 9);
    issue_start(4, 0);
    fifo_empty_in = 3'b100;
    fork
      wait_done(50, cyc);
      begin
        @(posedge clk);
        #1 fifo_empty_in = '0;
      end
    join
    check("inactive_empty_latency", cyc, 7);
    issue_start(2, 1);
    wait_done(50, cyc);
    check("offset_latency", cyc, 4);
    issue_start(0, 0);
    wait_done(50, cyc);
    check("degenerate_rc0", cyc, 0);
    issue_start(3, 5);
    wait_done(50, cyc);
    check("degenerate_offset", cyc, 0);
    issue_start(4, 0);
    fork
      wait_done(50, cyc);
      begin
        repeat (2) @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
      end
    join
    check("enable_pause_latency", cyc, 10);
    issue_start(4, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    issue_start(4, 0);
    wait_done(50, cyc);
    check("post_reset_latency", cyc, 7);
    for (int r = 0; r < 40; r++) begin
      int c;
      issue_start($urandom_range(0, 6), $urandom_range(0, 3));
      c = 0;
      while (!completed && c < 400) begin
        fifo_empty_in = n'($urandom & $urandom & $urandom);
        enable = ($urandom % 6) != 0;
        start = phase == 1 && ($urandom % 8) == 0;
        @(posedge clk); #1;
        c++;
      end
      start = 1'b0;
      enable = 1'b1;
      fifo_empty_in = '0;
      check("random_run_done", completed, 1);
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
